// File: rtl/leaky_relu_derivative_array_if.sv
// Bundle of the per-lane H push, gradient and result signals of the
// leaky-ReLU derivative array, plus the shared leak factor and flush.
interface leaky_relu_derivative_array_if #(
   parameter int NUM_COLS = 2,
   parameter int DATA_W   = 16
);
   logic [DATA_W-1:0]          lr_leak_factor_in;
   logic                       lr_d_flush_in;
   logic [NUM_COLS-1:0]        lr_d_h_valid_in;
   logic [NUM_COLS*DATA_W-1:0] lr_d_h_data_in;
   logic [NUM_COLS-1:0]        lr_d_valid_in;
   logic [NUM_COLS*DATA_W-1:0] lr_d_data_in;
   logic [NUM_COLS-1:0]        lr_d_valid_out;
   logic [NUM_COLS*DATA_W-1:0] lr_d_data_out;
   logic [NUM_COLS-1:0]        lr_d_h_full_out;
   logic [NUM_COLS-1:0]        lr_d_h_empty_out;
   logic [NUM_COLS-1:0]        lr_d_overflow_out;
   logic [NUM_COLS-1:0]        lr_d_underflow_out;

   modport master (
      output lr_leak_factor_in, lr_d_flush_in, lr_d_h_valid_in, lr_d_h_data_in,
             lr_d_valid_in, lr_d_data_in,
      input  lr_d_valid_out, lr_d_data_out, lr_d_h_full_out, lr_d_h_empty_out,
             lr_d_overflow_out, lr_d_underflow_out
   );

   modport slave (
      input  lr_leak_factor_in, lr_d_flush_in, lr_d_h_valid_in, lr_d_h_data_in,
             lr_d_valid_in, lr_d_data_in,
      output lr_d_valid_out, lr_d_data_out, lr_d_h_full_out, lr_d_h_empty_out,
             lr_d_overflow_out, lr_d_underflow_out
   );
endinterface

// File: rtl/leaky_relu_derivative_array.sv
// Backward-pass leaky-ReLU derivative for NUM_COLS independent lanes.
// Each lane keeps a circular cache of forward-pass signs (H > 0); every
// incoming gradient pops the oldest sign and is passed through or scaled by
// the leak factor with round-half-up and saturation. Two-stage pipeline.
module leaky_relu_derivative_array #(
   parameter int NUM_COLS = 2,
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 8,
   parameter int H_DEPTH  = 16
) (
   input logic clk,
   input logic rst,
   leaky_relu_derivative_array_if.slave bus
);

   localparam int PTR_W = $clog2(H_DEPTH);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(H_DEPTH);
   localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic signed [2*DATA_W:0] ROUND_C =
      {{(2*DATA_W+1-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
   localparam logic signed [2*DATA_W:0] SAT_MAX =
      {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [2*DATA_W:0] SAT_MIN =
      {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

   // sign cache state
   logic [H_DEPTH-1:0] sign_mem   [NUM_COLS];
   logic [PTR_W-1:0]   rd_ptr     [NUM_COLS];
   logic [PTR_W-1:0]   wr_ptr     [NUM_COLS];
   logic [PTR_W:0]     count      [NUM_COLS];
   logic [PTR_W:0]     count_next [NUM_COLS];
   logic [NUM_COLS-1:0] full_q, empty_q, overflow_q, underflow_q;

   // per-lane decode
   logic signed [DATA_W-1:0]   leak;
   logic signed [DATA_W-1:0]   h_lane    [NUM_COLS];
   logic signed [DATA_W-1:0]   grad_lane [NUM_COLS];
   logic signed [2*DATA_W-1:0] prod      [NUM_COLS];
   logic [NUM_COLS-1:0] cache_nonempty, cache_full, do_push, do_pop, push_pos;

   // pipeline state
   logic [NUM_COLS-1:0]        s1_valid, s1_pass, s1_zero;
   logic signed [DATA_W-1:0]   s1_grad [NUM_COLS];
   logic signed [2*DATA_W-1:0] s1_prod [NUM_COLS];
   logic signed [2*DATA_W:0]   rounded [NUM_COLS];
   logic signed [2*DATA_W:0]   shifted [NUM_COLS];
   logic signed [DATA_W-1:0]   result  [NUM_COLS];
   logic [NUM_COLS-1:0]        out_valid_q;
   logic [DATA_W-1:0]          out_data_q [NUM_COLS];

   assign leak = bus.lr_leak_factor_in;

   // Unpack lanes, decide push/pop per lane and form the full-width product.
   // A push on a full cache only lands if the same cycle also pops; a push on
   // an empty cache always lands even though the gradient underflows.
   always_comb begin
      for (int i = 0; i < NUM_COLS; i++) begin
         h_lane[i]         = bus.lr_d_h_data_in[i*DATA_W +: DATA_W];
         grad_lane[i]      = bus.lr_d_data_in[i*DATA_W +: DATA_W];
         prod[i]           = (2*DATA_W)'(grad_lane[i]) * (2*DATA_W)'(leak);
         cache_nonempty[i] = (count[i] != '0);
         cache_full[i]     = (count[i] == FULL_COUNT);
         do_pop[i]         = bus.lr_d_valid_in[i] && cache_nonempty[i];
         do_push[i]        = bus.lr_d_h_valid_in[i] && (!cache_full[i] || do_pop[i]);
         push_pos[i]       = !h_lane[i][DATA_W-1] && (h_lane[i] != '0);
         count_next[i]     = count[i];
         if (do_push[i] && !do_pop[i]) begin
            count_next[i] = count[i] + COUNT_ONE;
         end else if (do_pop[i] && !do_push[i]) begin
            count_next[i] = count[i] - COUNT_ONE;
         end
      end
   end

   // Pointers, occupancy and registered flags; flush returns them to reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         full_q      <= '0;
         empty_q     <= '1;
         overflow_q  <= '0;
         underflow_q <= '0;
      end else if (bus.lr_d_flush_in) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         full_q      <= '0;
         empty_q     <= '1;
         overflow_q  <= '0;
         underflow_q <= '0;
      end else begin
         for (int i = 0; i < NUM_COLS; i++) begin
            if (do_push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (do_pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            count[i]   <= count_next[i];
            full_q[i]  <= (count_next[i] == FULL_COUNT);
            empty_q[i] <= (count_next[i] == '0);
            if (bus.lr_d_h_valid_in[i] && cache_full[i] && !do_pop[i]) overflow_q[i] <= 1'b1;
            if (bus.lr_d_valid_in[i] && !cache_nonempty[i]) underflow_q[i] <= 1'b1;
         end
      end
   end

   // Sign storage needs no reset: entries are only read behind the write pointer.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_COLS; i++) begin
         if (!bus.lr_d_flush_in && do_push[i]) sign_mem[i][wr_ptr[i]] <= push_pos[i];
      end
   end

   // Stage 1: pop the sign, note underflow, capture gradient and product.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= '0;
         s1_pass  <= '0;
         s1_zero  <= '0;
         for (int i = 0; i < NUM_COLS; i++) begin
            s1_grad[i] <= '0;
            s1_prod[i] <= '0;
         end
      end else if (bus.lr_d_flush_in) begin
         s1_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_COLS; i++) begin
            s1_valid[i] <= bus.lr_d_valid_in[i];
            s1_zero[i]  <= !cache_nonempty[i];
            s1_pass[i]  <= sign_mem[i][rd_ptr[i]];
            s1_grad[i]  <= grad_lane[i];
            s1_prod[i]  <= prod[i];
         end
      end
   end

   // Round half toward +inf, drop the fraction, clamp, then pick the result.
   always_comb begin
      for (int i = 0; i < NUM_COLS; i++) begin
         rounded[i] = {s1_prod[i][2*DATA_W-1], s1_prod[i]} + ROUND_C;
         shifted[i] = rounded[i] >>> FRAC_W;
         if (s1_zero[i]) begin
            result[i] = '0;
         end else if (s1_pass[i]) begin
            result[i] = s1_grad[i];
         end else if (shifted[i] > SAT_MAX) begin
            result[i] = SAT_MAX[DATA_W-1:0];
         end else if (shifted[i] < SAT_MIN) begin
            result[i] = SAT_MIN[DATA_W-1:0];
         end else begin
            result[i] = shifted[i][DATA_W-1:0];
         end
      end
   end

   // Stage 2: register the final per-lane result and its valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= '0;
         for (int i = 0; i < NUM_COLS; i++) out_data_q[i] <= '0;
      end else if (bus.lr_d_flush_in) begin
         out_valid_q <= '0;
         for (int i = 0; i < NUM_COLS; i++) out_data_q[i] <= '0;
      end else begin
         out_valid_q <= s1_valid;
         for (int i = 0; i < NUM_COLS; i++) begin
            if (s1_valid[i]) out_data_q[i] <= result[i];
         end
      end
   end

   // Repack lane results onto the output bus.
   always_comb begin
      bus.lr_d_data_out = '0;
      for (int i = 0; i < NUM_COLS; i++) begin
         bus.lr_d_data_out[i*DATA_W +: DATA_W] = out_data_q[i];
      end
   end

   assign bus.lr_d_valid_out     = out_valid_q;
   assign bus.lr_d_h_full_out    = full_q;
   assign bus.lr_d_h_empty_out   = empty_q;
   assign bus.lr_d_overflow_out  = overflow_q;
   assign bus.lr_d_underflow_out = underflow_q;

endmodule

// File: tb/tb_leaky_relu_derivative_array.sv
// Scoreboard bench for leaky_relu_derivative_array (2 lanes, depth-4 caches).
// Stimulus enqueues hand-computed results with their due cycle; a monitor on
// the falling edge pops and compares whenever a lane presents a valid.
module tb_leaky_relu_derivative_array;

   localparam int NUM_COLS = 2;
   localparam int DATA_W   = 16;
   localparam int FRAC_W   = 8;
   localparam int H_DEPTH  = 4;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   cycle_count;
   exp_t sb_q [NUM_COLS][$];

   leaky_relu_derivative_array_if #(.NUM_COLS(NUM_COLS), .DATA_W(DATA_W)) bus ();

   leaky_relu_derivative_array #(
      .NUM_COLS(NUM_COLS), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .H_DEPTH(H_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // cycle counter used to check latency of each popped result
   always @(posedge clk) cycle_count <= cycle_count + 1;

   // one comparison; steps the counters printed in the summary
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
      end
   endtask

   // drive one cycle of pushes/gradients, enqueue expectations, then idle the strobes
   task automatic applyStimulus(input logic [1:0] hv, input logic [31:0] hd,
                                input logic [1:0] gv, input logic [31:0] gd,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input bit track);
      exp_t e;
      bus.lr_d_h_valid_in = hv;
      bus.lr_d_h_data_in  = hd;
      bus.lr_d_valid_in   = gv;
      bus.lr_d_data_in    = gd;
      if (track) begin
         e.due = cycle_count + 2;
         if (gv[0]) begin e.data = e0; sb_q[0].push_back(e); end
         if (gv[1]) begin e.data = e1; sb_q[1].push_back(e); end
      end
      @(posedge clk);
      #1;
      bus.lr_d_h_valid_in = '0;
      bus.lr_d_h_data_in  = '0;
      bus.lr_d_valid_in   = '0;
      bus.lr_d_data_in    = '0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(2'b00, 32'h0, 2'b00, 32'h0, 16'h0, 16'h0, 1'b0);
   endtask

   // monitor: compare every presented result against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            if (bus.lr_d_valid_out[i] === 1'b1) begin
               if (sb_q[i].size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_valid lane%0d: got valid=1 data=0x%0h, wanted no valid",
                           i, bus.lr_d_data_out[i*DATA_W +: DATA_W]);
               end else begin
                  e = sb_q[i].pop_front();
                  checkOutput($sformatf("data_lane%0d", i), 32'(bus.lr_d_data_out[i*DATA_W +: DATA_W]), 32'(e.data));
                  checkOutput($sformatf("latency_lane%0d", i), 32'(cycle_count), 32'(e.due));
               end
            end
         end
      end
   end

   // watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, wanted completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"},     32'(bus.lr_d_valid_out),     32'h0);
      checkOutput({tag, "_data"},      32'(bus.lr_d_data_out),      32'h0);
      checkOutput({tag, "_full"},      32'(bus.lr_d_h_full_out),    32'h0);
      checkOutput({tag, "_empty"},     32'(bus.lr_d_h_empty_out),   32'h3);
      checkOutput({tag, "_overflow"},  32'(bus.lr_d_overflow_out),  32'h0);
      checkOutput({tag, "_underflow"}, 32'(bus.lr_d_underflow_out), 32'h0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      cycle_count = 0;
      rst = 1'b0;
      bus.lr_leak_factor_in = 16'h0040;
      bus.lr_d_flush_in   = 1'b0;
      bus.lr_d_h_valid_in = '0;
      bus.lr_d_h_data_in  = '0;
      bus.lr_d_valid_in   = '0;
      bus.lr_d_data_in    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;

      // basic pass and leak paths
      applyStimulus(2'b11, {16'hFFFF, 16'h0005}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b11, {16'h0200, 16'h0200}, 16'h0200, 16'h0080, 1'b1);
      idle(3);
      checkOutput("empty_after_basic", 32'(bus.lr_d_h_empty_out), 32'h3);

      // rounding and zero-H, leak 0.5
      bus.lr_leak_factor_in = 16'h0080;
      applyStimulus(2'b11, {16'h0000, 16'hFFFF}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b11, {16'h0100, 16'h0003}, 16'h0002, 16'h0080, 1'b1);
      applyStimulus(2'b01, {16'h0000, 16'hFFFF}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b01, {16'h0000, 16'hFFFD}, 16'hFFFF, 16'h0, 1'b1);

      // saturation, leak just under 128
      bus.lr_leak_factor_in = 16'h7FFF;
      applyStimulus(2'b11, {16'h8000, 16'h8000}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b11, {16'h8000, 16'h7FFF}, 16'h7FFF, 16'h8000, 1'b1);
      idle(2);

      // cache order and overflow, lanes interleaved with different patterns
      bus.lr_leak_factor_in = 16'h0040;
      applyStimulus(2'b11, {16'hFFFF, 16'h0001}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b11, {16'h0001, 16'hFFFF}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b01, {16'h0000, 16'h0001}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b01, {16'h0000, 16'hFFFF}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      checkOutput("full_after_4", 32'(bus.lr_d_h_full_out), 32'h1);
      checkOutput("overflow_before_5th", 32'(bus.lr_d_overflow_out), 32'h0);
      applyStimulus(2'b01, {16'h0000, 16'h0001}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      checkOutput("full_after_5th", 32'(bus.lr_d_h_full_out), 32'h1);
      checkOutput("overflow_after_5th", 32'(bus.lr_d_overflow_out), 32'h1);
      applyStimulus(2'b00, 32'h0, 2'b11, {16'h0100, 16'h0100}, 16'h0100, 16'h0040, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b11, {16'h0100, 16'h0100}, 16'h0040, 16'h0100, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b01, {16'h0000, 16'h0100}, 16'h0100, 16'h0, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b01, {16'h0000, 16'h0100}, 16'h0040, 16'h0, 1'b1);
      checkOutput("empty_after_drain", 32'(bus.lr_d_h_empty_out), 32'h3);

      // underflow on an empty lane still yields a zero beat
      applyStimulus(2'b00, 32'h0, 2'b10, {16'h0100, 16'h0000}, 16'h0, 16'h0000, 1'b1);
      checkOutput("underflow_set", 32'(bus.lr_d_underflow_out), 32'h2);

      // push+pop while full keeps count; push+pop on empty stores the entry
      for (int k = 0; k < 4; k++)
         applyStimulus(2'b01, {16'h0000, 16'h8000}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      checkOutput("full_refill", 32'(bus.lr_d_h_full_out), 32'h1);
      applyStimulus(2'b01, {16'h0000, 16'h0001}, 2'b01, {16'h0000, 16'h0100}, 16'h0040, 16'h0, 1'b1);
      checkOutput("full_after_push_pop", 32'(bus.lr_d_h_full_out), 32'h1);
      applyStimulus(2'b10, {16'h0001, 16'h0000}, 2'b11, {16'h0100, 16'h0100}, 16'h0040, 16'h0000, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b11, {16'h0100, 16'h0100}, 16'h0040, 16'h0100, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b01, {16'h0000, 16'h0100}, 16'h0040, 16'h0, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b01, {16'h0000, 16'h0100}, 16'h0100, 16'h0, 1'b1);
      checkOutput("empty_after_concurrency", 32'(bus.lr_d_h_empty_out), 32'h3);

      // flush with three entries cached and one beat in flight
      applyStimulus(2'b01, {16'h0000, 16'h0001}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b01, {16'h0000, 16'hFFFF}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b01, {16'h0000, 16'h0001}, 2'b00, 32'h0, 16'h0, 16'h0, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b01, {16'h0000, 16'h0100}, 16'h0, 16'h0, 1'b0);
      bus.lr_d_flush_in = 1'b1;
      @(posedge clk);
      #1;
      bus.lr_d_flush_in = 1'b0;
      checkResetOutputs("flush");
      idle(3);

      // traffic after the flush proceeds normally
      applyStimulus(2'b01, {16'h0000, 16'h0010}, 2'b10, {16'h0100, 16'h0000}, 16'h0, 16'h0000, 1'b1);
      applyStimulus(2'b01, {16'h0000, 16'h0010}, 2'b01, {16'h0000, 16'h0123}, 16'h0123, 16'h0, 1'b1);
      applyStimulus(2'b00, 32'h0, 2'b01, {16'h0000, 16'h0011}, 16'h0, 16'h0, 1'b0);
      applyStimulus(2'b01, {16'h0000, 16'h0010}, 2'b01, {16'h0000, 16'h0012}, 16'h0, 16'h0, 1'b0);
      checkOutput("pre_reset_valid", 32'(bus.lr_d_valid_out), 32'h1);
      checkOutput("pre_reset_data", 32'(bus.lr_d_data_out[15:0]), 32'h0011);

      // asynchronous reset mid-stream clears outputs immediately
      #2;
      rst = 1'b0;
      #1;
      checkResetOutputs("midreset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle(5);

      for (int i = 0; i < NUM_COLS; i++)
         checkOutput($sformatf("scoreboard_drained_lane%0d", i), 32'(sb_q[i].size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
